// File: rtl/flash_reader_pkg.sv
// Shared constants, state encoding and helpers for the flash sample reader.
package flash_reader_pkg;

   localparam int SAMPLE_W = 16;
   localparam int WORD_W   = 32;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE      = 3'd0;
   localparam state_t ST_REQ       = 3'd1;
   localparam state_t ST_WAIT_DATA = 3'd2;
   localparam state_t ST_HALF1     = 3'd3;
   localparam state_t ST_HALF2     = 3'd4;
   localparam state_t ST_ADV       = 3'd5;

   // Width of a counter that must be able to reach the timeout value itself.
   function automatic int timeout_cnt_w(input int timeout);
      return $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/flash_sample_reader_avalon_read_port.sv
// Single-word Avalon-MM read master: issues one read on start, holds it
// through waitrequest, then waits for readdatavalid or gives up on timeout.
module avalon_read_port
   import flash_reader_pkg::*;
#(
   parameter int ADDR_W  = 23,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] address,
   output logic              accepted,
   output logic              done,
   output logic              err,
   output logic [WORD_W-1:0] data,
   output logic              flash_read,
   output logic [ADDR_W-1:0] flash_address,
   input  logic              flash_waitrequest,
   input  logic [WORD_W-1:0] flash_readdata,
   input  logic              flash_readdatavalid
);

   localparam int CNT_W = timeout_cnt_w(TIMEOUT);

   logic             waiting;
   logic [CNT_W-1:0] cnt;

   assign accepted = flash_read && !flash_waitrequest;
   assign done     = waiting && flash_readdatavalid;
   assign err      = waiting && !flash_readdatavalid && (cnt == CNT_W'(TIMEOUT - 1));
   assign data     = flash_readdata;

   // Request phase: raise read with the captured address, drop it once accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flash_read    <= 1'b0;
         flash_address <= '0;
      end else if (start) begin
         flash_read    <= 1'b1;
         flash_address <= address;
      end else if (accepted) begin
         flash_read    <= 1'b0;
      end
   end

   // Data phase: count cycles until data returns or the timeout expires.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         waiting <= 1'b0;
         cnt     <= '0;
      end else if (accepted) begin
         waiting <= 1'b1;
         cnt     <= '0;
      end else if (done || err) begin
         waiting <= 1'b0;
      end else if (waiting) begin
         cnt     <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/flash_sample_reader.sv
// Fetches one 32-bit flash word per sequencer address and releases it as two
// 16-bit audio samples, one per sample tick, then asks the sequencer to step.
module flash_sample_reader
   import flash_reader_pkg::*;
#(
   parameter int ADDR_W  = 23,
   parameter int TIMEOUT = 1024
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                sample_tick,
   input  logic                hold,
   input  logic                reverse,
   input  logic [ADDR_W-1:0]   address,
   output logic                addr_advance,
   output logic                flash_read,
   output logic [ADDR_W-1:0]   flash_address,
   input  logic                flash_waitrequest,
   input  logic [WORD_W-1:0]   flash_readdata,
   input  logic                flash_readdatavalid,
   output logic [SAMPLE_W-1:0] audio_sample,
   output logic                sample_valid,
   output logic                overrun,
   output logic                timeout_err
);

   state_t              state;
   logic [WORD_W-1:0]   word;
   logic [WORD_W-1:0]   rd_data;
   logic                pending;
   logic                rev_held;
   logic                start;
   logic                accepted;
   logic                done;
   logic                err;
   logic                tick_in;
   logic                in_half;
   logic                emit;
   logic [SAMPLE_W-1:0] half_sel;

   assign tick_in = sample_tick && !hold;
   assign in_half = (state == ST_HALF1) || (state == ST_HALF2);
   assign emit    = in_half && !hold && (pending || tick_in);
   assign start   = (state == ST_IDLE) && !hold;

   avalon_read_port #(
      .ADDR_W  (ADDR_W),
      .TIMEOUT (TIMEOUT)
   ) u_port (
      .clk                 (clk),
      .rst_n               (rst_n),
      .start               (start),
      .address             (address),
      .accepted            (accepted),
      .done                (done),
      .err                 (err),
      .data                (rd_data),
      .flash_read          (flash_read),
      .flash_address       (flash_address),
      .flash_waitrequest   (flash_waitrequest),
      .flash_readdata      (flash_readdata),
      .flash_readdatavalid (flash_readdatavalid)
   );

   // Pick the half to emit: first half follows reverse now, second half the opposite of what was used first.
   always_comb begin
      half_sel = word[SAMPLE_W-1:0];
      if (state == ST_HALF1) begin
         half_sel = reverse ? word[WORD_W-1:SAMPLE_W] : word[SAMPLE_W-1:0];
      end else begin
         half_sel = rev_held ? word[SAMPLE_W-1:0] : word[WORD_W-1:SAMPLE_W];
      end
   end

   // Main sequence: fetch, wait for data, emit two halves, advance the sequencer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         word        <= '0;
         rev_held    <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         case (state)
            ST_IDLE:      if (!hold) state <= ST_REQ;
            ST_REQ:       if (accepted) state <= ST_WAIT_DATA;
            ST_WAIT_DATA: begin
               if (done) begin
                  word  <= rd_data;
                  state <= ST_HALF1;
               end else if (err) begin
                  word        <= '0;
                  timeout_err <= 1'b1;
                  state       <= ST_IDLE;
               end
            end
            ST_HALF1: begin
               if (emit) begin
                  rev_held <= reverse;
                  state    <= ST_HALF2;
               end
            end
            ST_HALF2:     if (emit) state <= ST_ADV;
            ST_ADV:       state <= ST_IDLE;
            default:      state <= ST_IDLE;
         endcase
      end
   end

   // Registered sample output and the one-cycle advance pulse after the second half.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         audio_sample <= '0;
         sample_valid <= 1'b0;
         addr_advance <= 1'b0;
      end else begin
         sample_valid <= emit;
         addr_advance <= (state == ST_ADV);
         if (emit) audio_sample <= half_sel;
      end
   end

   // Ticks outside the emitting states are remembered once; a second one is an overrun.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= 1'b0;
         overrun <= 1'b0;
      end else if (in_half) begin
         if (emit && pending) pending <= tick_in;
      end else if (tick_in) begin
         if (pending) overrun <= 1'b1;
         else         pending <= 1'b1;
      end
   end

endmodule

// File: tb/tb_flash_sample_reader.sv
// Directed bench for flash_sample_reader with a word-level reference model
// and a per-cycle compare process.
module tb_flash_sample_reader;

   localparam logic [22:0] ADDR_VAL = 23'd59072;

   logic        clk;
   logic        rst_n;
   logic        sample_tick, hold, reverse;
   logic [22:0] address;
   logic        addr_advance, flash_read, sample_valid, overrun, timeout_err;
   logic [22:0] flash_address;
   logic        flash_waitrequest, flash_readdatavalid;
   logic [31:0] flash_readdata;
   logic [15:0] audio_sample;

   logic        sample_tick_to, hold_to, reverse_to;
   logic [22:0] address_to;
   logic        addr_advance_to, flash_read_to, sample_valid_to, overrun_to, timeout_err_to;
   logic [22:0] flash_address_to;
   logic        flash_waitrequest_to, flash_readdatavalid_to;
   logic [31:0] flash_readdata_to;
   logic [15:0] audio_sample_to;

   int checks   = 0;
   int failures = 0;

   logic [31:0] resp_word;
   int          resp_latency;
   int          wait_cycles;
   int          lat_cnt;
   int          req_cycles;

   logic [31:0] word_q[$];
   int          half_idx;
   logic        model_rev;
   logic        rev_prev;
   logic [15:0] exp_last;
   logic [15:0] exp_val;
   logic [31:0] w;
   logic        adv_due;
   logic        second;
   int          sv_count;
   int          accept_cnt;
   int          sv_to_count;
   int          adv_to_count;

   flash_sample_reader #(.ADDR_W(23), .TIMEOUT(1024)) dut (
      .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .hold(hold),
      .reverse(reverse), .address(address), .addr_advance(addr_advance),
      .flash_read(flash_read), .flash_address(flash_address),
      .flash_waitrequest(flash_waitrequest), .flash_readdata(flash_readdata),
      .flash_readdatavalid(flash_readdatavalid), .audio_sample(audio_sample),
      .sample_valid(sample_valid), .overrun(overrun), .timeout_err(timeout_err)
   );

   flash_sample_reader #(.ADDR_W(23), .TIMEOUT(16)) dut_to (
      .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick_to), .hold(hold_to),
      .reverse(reverse_to), .address(address_to), .addr_advance(addr_advance_to),
      .flash_read(flash_read_to), .flash_address(flash_address_to),
      .flash_waitrequest(flash_waitrequest_to), .flash_readdata(flash_readdata_to),
      .flash_readdatavalid(flash_readdatavalid_to), .audio_sample(audio_sample_to),
      .sample_valid(sample_valid_to), .overrun(overrun_to), .timeout_err(timeout_err_to)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // The second instance sees a flash that accepts reads but never returns data.
   initial begin
      sample_tick_to = 1'b0; hold_to = 1'b0; reverse_to = 1'b0;
      address_to = 23'd77; flash_waitrequest_to = 1'b0;
      flash_readdatavalid_to = 1'b0; flash_readdata_to = 32'h0;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_tick();
      sample_tick = 1'b1;
      @(posedge clk);
      #1;
      sample_tick = 1'b0;
   endtask

   task automatic applyStimulus(input logic [31:0] word, input int latency, input int waits, input logic rev);
      hold = 1'b1; sample_tick = 1'b0; rst_n = 1'b0;
      resp_word = word; resp_latency = latency; wait_cycles = waits;
      reverse = rev; address = ADDR_VAL;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      hold = 1'b0;
   endtask

   // Avalon slave model: programmable waitrequest stall and read latency.
   initial begin
      flash_waitrequest = 1'b0; flash_readdatavalid = 1'b0; flash_readdata = 32'h0;
      lat_cnt = 0; req_cycles = 0;
      forever begin
         @(posedge clk);
         #1;
         flash_readdatavalid = 1'b0;
         if (!rst_n) begin
            lat_cnt = 0; req_cycles = 0; flash_waitrequest = 1'b0;
         end else begin
            if (lat_cnt > 0) begin
               lat_cnt--;
               if (lat_cnt == 0) begin
                  flash_readdatavalid = 1'b1;
                  flash_readdata = resp_word;
                  word_q.push_back(resp_word);
               end
            end
            if (flash_read) begin
               flash_waitrequest = (req_cycles < wait_cycles);
               if (!flash_waitrequest) lat_cnt = resp_latency;
               req_cycles++;
            end else begin
               flash_waitrequest = 1'b0;
               req_cycles = 0;
            end
         end
      end
   end

   // Word-level model: each delivered word yields its two halves in the order
   // chosen by reverse at the first emission, then one advance pulse.
   always @(negedge clk) begin
      if (!rst_n) begin
         word_q.delete();
         half_idx = 0; exp_last = 16'h0; adv_due = 1'b0;
         sv_count = 0; accept_cnt = 0; sv_to_count = 0; adv_to_count = 0;
         rev_prev = reverse;
      end else begin
         second = 1'b0;
         if (sample_valid) begin
            sv_count++;
            if (word_q.size() == 0) begin
               checks++; failures++;
               $display("[TB] FAIL cmp_word_available actual=empty expected=word");
            end else begin
               w = word_q[0];
               if (half_idx == 0) begin
                  model_rev = rev_prev;
                  exp_val = rev_prev ? w[31:16] : w[15:0];
                  half_idx = 1;
               end else begin
                  exp_val = model_rev ? w[15:0] : w[31:16];
                  half_idx = 0;
                  void'(word_q.pop_front());
                  second = 1'b1;
               end
               exp_last = exp_val;
            end
         end
         checkOutput("cmp_audio_sample", 32'(audio_sample), 32'(exp_last));
         checkOutput("cmp_addr_advance", 32'(addr_advance), 32'(adv_due));
         adv_due = second;
         if (flash_read) checkOutput("cmp_flash_address", 32'(flash_address), 32'(address));
         checkOutput("cmp_timeout_err", 32'(timeout_err), 32'h0);
         if (flash_read && !flash_waitrequest) accept_cnt++;
         if (sample_valid_to) sv_to_count++;
         if (addr_advance_to) adv_to_count++;
         rev_prev = reverse;
      end
   end

   // Directed scenarios with hand-computed expectations.
   initial begin
      int n;
      logic got;
      rst_n = 1'b0; hold = 1'b1; sample_tick = 1'b0; reverse = 1'b0; address = ADDR_VAL;
      resp_word = 32'h0; resp_latency = 3; wait_cycles = 0;
      repeat (2) @(negedge clk);
      checkOutput("rst_flash_read", 32'(flash_read), 32'h0);
      checkOutput("rst_flash_address", 32'(flash_address), 32'h0);
      checkOutput("rst_sample_valid", 32'(sample_valid), 32'h0);
      checkOutput("rst_audio_sample", 32'(audio_sample), 32'h0);
      checkOutput("rst_addr_advance", 32'(addr_advance), 32'h0);
      checkOutput("rst_overrun", 32'(overrun), 32'h0);

      $display("[TB] forward playback");
      applyStimulus(32'hAAAA_5555, 3, 0, 1'b0);
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (flash_read) got = 1'b1;
      end
      checkOutput("fwd_read_seen", 32'(got), 32'h1);
      checkOutput("fwd_flash_address", 32'(flash_address), 32'd59072);
      step(20);
      pulse_tick();
      @(negedge clk);
      checkOutput("fwd_valid1", 32'(sample_valid), 32'h1);
      checkOutput("fwd_sample1", 32'(audio_sample), 32'h5555);
      @(negedge clk);
      checkOutput("fwd_valid1_width", 32'(sample_valid), 32'h0);
      step(998);
      pulse_tick();
      @(negedge clk);
      checkOutput("fwd_sample2", 32'(audio_sample), 32'hAAAA);
      checkOutput("fwd_adv_early", 32'(addr_advance), 32'h0);
      @(negedge clk);
      checkOutput("fwd_adv", 32'(addr_advance), 32'h1);
      @(negedge clk);
      checkOutput("fwd_adv_width", 32'(addr_advance), 32'h0);

      $display("[TB] reverse playback");
      applyStimulus(32'hAAAA_5555, 3, 0, 1'b1);
      step(20);
      pulse_tick();
      @(negedge clk);
      checkOutput("rev_sample1", 32'(audio_sample), 32'hAAAA);
      step(1);
      reverse = 1'b0;
      step(5);
      pulse_tick();
      @(negedge clk);
      checkOutput("rev_sample2", 32'(audio_sample), 32'h5555);

      $display("[TB] waitrequest stall");
      applyStimulus(32'h1234_ABCD, 3, 5, 1'b0);
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (flash_read) got = 1'b1;
      end
      checkOutput("stall_read_seen", 32'(got), 32'h1);
      n = 0;
      while (flash_read && n < 40) begin
         n++;
         @(negedge clk);
      end
      checkOutput("stall_read_cycles", 32'(n), 32'd6);
      step(15);
      checkOutput("stall_accept_count", 32'(accept_cnt), 32'd1);
      pulse_tick();
      @(negedge clk);
      checkOutput("stall_sample1", 32'(audio_sample), 32'hABCD);
      step(3);
      pulse_tick();
      @(negedge clk);
      checkOutput("stall_sample2", 32'(audio_sample), 32'h1234);

      $display("[TB] pending tick");
      applyStimulus(32'hCAFE_BEEF, 20, 0, 1'b0);
      step(5);
      pulse_tick();
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (flash_readdatavalid) got = 1'b1;
      end
      checkOutput("pend_data_seen", 32'(got), 32'h1);
      @(negedge clk);
      checkOutput("pend_not_yet", 32'(sample_valid), 32'h0);
      @(negedge clk);
      checkOutput("pend_valid", 32'(sample_valid), 32'h1);
      checkOutput("pend_sample", 32'(audio_sample), 32'hBEEF);
      checkOutput("pend_no_overrun", 32'(overrun), 32'h0);

      $display("[TB] overrun");
      applyStimulus(32'h0F0F_7070, 20, 0, 1'b0);
      step(4);
      pulse_tick();
      step(2);
      pulse_tick();
      step(30);
      checkOutput("ovr_flag", 32'(overrun), 32'h1);
      checkOutput("ovr_one_sample", 32'(sv_count), 32'd1);
      checkOutput("ovr_sample", 32'(audio_sample), 32'h7070);

      $display("[TB] hold in second half");
      applyStimulus(32'h1111_2222, 3, 0, 1'b0);
      step(20);
      pulse_tick();
      @(negedge clk);
      checkOutput("hold_sample1", 32'(audio_sample), 32'h2222);
      step(1);
      hold = 1'b1;
      step(3);
      pulse_tick();
      step(5);
      pulse_tick();
      step(5);
      checkOutput("hold_no_samples", 32'(sv_count), 32'd1);
      checkOutput("hold_frozen", 32'(audio_sample), 32'h2222);
      hold = 1'b0;
      step(3);
      checkOutput("hold_no_overrun", 32'(overrun), 32'h0);
      pulse_tick();
      @(negedge clk);
      checkOutput("hold_release_valid", 32'(sample_valid), 32'h1);
      checkOutput("hold_release_sample", 32'(audio_sample), 32'h1111);

      $display("[TB] read timeout");
      applyStimulus(32'h0, 3, 0, 1'b0);
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (flash_read_to) got = 1'b1;
      end
      checkOutput("to_read_seen", 32'(got), 32'h1);
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (!flash_read_to) got = 1'b1;
      end
      checkOutput("to_read_dropped", 32'(got), 32'h1);
      n = 0;
      while (!timeout_err_to && n < 40) begin
         @(negedge clk);
         n++;
      end
      checkOutput("to_wait_cycles", 32'(n), 32'd16);
      checkOutput("to_idle_gap", 32'(flash_read_to), 32'h0);
      @(negedge clk);
      checkOutput("to_new_req", 32'(flash_read_to), 32'h1);
      checkOutput("to_no_sample", 32'(sv_to_count), 32'd0);
      checkOutput("to_no_advance", 32'(adv_to_count), 32'd0);

      $display("[TB] reset during request");
      applyStimulus(32'h5A5A_A5A5, 3, 50, 1'b0);
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (flash_read) got = 1'b1;
      end
      checkOutput("rreq_read_seen", 32'(got), 32'h1);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("rreq_flash_read", 32'(flash_read), 32'h0);
      checkOutput("rreq_flash_address", 32'(flash_address), 32'h0);
      checkOutput("rreq_sample_valid", 32'(sample_valid), 32'h0);
      checkOutput("rreq_audio_sample", 32'(audio_sample), 32'h0);
      checkOutput("rreq_addr_advance", 32'(addr_advance), 32'h0);
      checkOutput("rreq_overrun", 32'(overrun), 32'h0);
      checkOutput("rreq_timeout_err", 32'(timeout_err), 32'h0);
      step(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/flash_sample_reader.md
Name: flash_sample_reader

Overview:
- Downstream consumer of the address sequencer's word address. It fetches one 32-bit flash word per address over an Avalon-MM read master.
- Each word is split into two 16-bit audio samples, released one per audio-rate tick, and the block pulses `addr_advance` when both halves are consumed.
- It sits between the address sequencer and the audio codec interface of the Simple iPod player.

Parameters:
- ADDR_W, 23, flash word-address width.
- TIMEOUT, 1024, max clk cycles to wait for readdatavalid before flagging an error.

Ports:
- clk  in  1  system clock (50 MHz).
- rst_n  in  1  asynchronous, active-low reset.
- sample_tick  in  1  one-cycle strobe at the audio sample rate (22 kHz nominal).
- hold  in  1  pause: no new fetches, no new samples.
- reverse  in  1  0 = forward playback, 1 = backward playback.
- address  in  ADDR_W  current word address from the sequencer; stable until addr_advance.
- addr_advance  out  1  one-cycle pulse: current word fully consumed, sequencer steps.
- flash_read  out  1  Avalon read request.
- flash_address  out  ADDR_W  Avalon address, registered.
- flash_waitrequest  in  1  Avalon waitrequest.
- flash_readdata  in  32  Avalon read data.
- flash_readdatavalid  in  1  Avalon data-valid strobe.
- audio_sample  out  16  current sample (two's complement), registered.
- sample_valid  out  1  one-cycle pulse when audio_sample updates.
- overrun  out  1  sticky: a tick arrived while one was already pending.
- timeout_err  out  1  sticky: a read exceeded TIMEOUT cycles.

Behaviour:
- Reset state:
  - All outputs 0; FSM = IDLE.
  - The word latch and the pending flag are cleared.
  - Asserting rst_n low mid-read drops flash_read immediately; a late readdatavalid after reset is ignored.
- FSM states: IDLE, REQ, WAIT_DATA, HALF1, HALF2, ADV.
- IDLE:
  - If hold = 0, go to REQ on the next cycle (prefetch, no tick needed).
- REQ:
  - flash_read = 1 and flash_address = address (captured on entry).
  - Stay while waitrequest = 1.
  - On the cycle waitrequest = 0, drop flash_read next cycle and go to WAIT_DATA.
- WAIT_DATA:
  - On readdatavalid, latch readdata and go to HALF1.
  - A timeout counter increments each cycle. At TIMEOUT, set timeout_err, drop the word and return to IDLE; no addr_advance.
- HALF1:
  - On a tick (or a pending tick), emit the first half and go to HALF2.
  - First half is readdata[15:0] when reverse = 0, readdata[31:16] when reverse = 1.
  - reverse is sampled at HALF1 emission and held for HALF2.
- HALF2:
  - On the next tick, emit the other half and go to ADV.
- ADV:
  - Pulse addr_advance for 1 cycle, then go to IDLE.
  - Net effect: the next fetch starts 2 cycles after the HALF2 emission.
- Emission timing:
  - audio_sample and sample_valid update on the clock edge after the tick is seen (latency 1 cycle).
  - sample_valid stays high for exactly 1 cycle.
- Tick handling:
  - A tick seen in IDLE, REQ, WAIT_DATA or ADV sets `pending`.
  - A tick arriving while pending = 1 sets overrun; the extra tick is dropped.
  - In HALF1/HALF2, pending is consumed first. A tick on the same cycle as pending consumption becomes the new pending.
- hold:
  - While hold = 1, ticks are ignored, pending is not set, and IDLE does not fetch.
  - An in-flight REQ/WAIT_DATA completes normally and the latched word is retained.
  - audio_sample keeps its last value.
- Simultaneous events:
  - readdatavalid outside WAIT_DATA is ignored.
  - A tick and readdatavalid in the same cycle: the tick becomes pending, and HALF1 emits it on the next cycle.
- Sticky flags (overrun, timeout_err) clear only on reset.

Decomposition:
- Package flash_reader_pkg holds:
  - the FSM state enum;
  - the constants SAMPLE_W = 16 and WORD_W = 32;
  - the timeout counter width, $clog2(TIMEOUT+1).
- One natural sub-module, avalon_read_port: REQ/WAIT_DATA handshake plus timeout counter.
  - Interface: start, address → done, data, err.
- Tick/pending logic and half selection stay in the top level.

Test Plan:
- Forward basic:
  - Stimulus: address = 59072, readdata = 0xAAAA_5555, waitrequest low, 3-cycle data latency, two ticks 1000 cycles apart.
  - Required: samples 0x5555 then 0xAAAA, then addr_advance 1 cycle after the 2nd sample_valid.
  - Also required: flash_address = 59072 throughout the read.
- Reverse:
  - Stimulus: same word with reverse = 1.
  - Required: 0xAAAA then 0x5555.
  - Also required: toggling reverse between the two halves does not change the order.
- Waitrequest stall:
  - Stimulus: waitrequest high for 5 cycles.
  - Required: flash_read held 6 cycles with a stable address, exactly one request accepted, and correct data.
- Pending/overrun:
  - Stimulus: a tick during WAIT_DATA (latency 20).
  - Required: the sample is emitted 1 cycle after readdatavalid.
  - Stimulus: two ticks during WAIT_DATA.
  - Required: overrun = 1, only one sample emitted.
- Timeout:
  - Stimulus: readdatavalid never asserted, TIMEOUT = 16.
  - Required: timeout_err = 1 after 16 cycles in WAIT_DATA, no sample_valid, no addr_advance, and a new REQ follows.
- Hold and reset:
  - Stimulus: hold = 1 in HALF2.
  - Required: ticks are ignored and audio_sample is frozen; after release, the next tick emits the 2nd half.
  - Stimulus: rst_n low during REQ.
  - Required: flash_read drops without waiting for a clock edge and all outputs read 0.
